// File: rtl/scan_mux_pkg.sv
// Shared types and helpers for the scan_mux block: FSM state encoding and
// the set-bit priority search used to walk the channel mask.
package scan_mux_pkg;

  localparam int MAX_CH = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Returns {found, index} of the lowest set bit above pos (or at pos when incl).
  function automatic logic [6:0] next_set(input logic [MAX_CH-1:0] mask,
                                          input logic [5:0]        pos,
                                          input logic              incl);
    logic [6:0] r;
    r = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(pos)) || (incl && (i == int'(pos)))))
        r = {1'b1, 6'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_mux_next_ch.sv
// Combinational priority encoder: next enabled channel at/above a pointer.
module scan_mux_next_ch
  import scan_mux_pkg::*;
#(
  parameter  int NUM_CH = 8,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   ptr,
  input  logic              incl,
  output logic [CH_W-1:0]   nxt,
  output logic              found
);

  logic [MAX_CH-1:0] mask_ext;
  logic [5:0]        pos;
  logic [6:0]        res;

  always_comb begin
    mask_ext               = '0;
    mask_ext[NUM_CH-1:0]   = mask;
    pos                    = '0;
    pos[CH_W-1:0]          = ptr;
    res                    = next_set(mask_ext, pos, incl);
  end

  assign nxt   = res[CH_W-1:0];
  assign found = res[6];

  // High index bits are always zero for narrow configurations.
  logic unused_hi;
  assign unused_hi = ^res[5:0];

endmodule

// File: rtl/scan_mux.sv
// Registered N-channel mux with direct-select and mask-scan modes, valid/ready out.
// Optional OutParity output when SCAN_MUX_PARITY_EN is defined.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter  int NUM_CH = 8,
  parameter  int DATA_W = 1,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  input  logic [NUM_CH*DATA_W-1:0] MuxIn,
  input  logic [CH_W-1:0]          MuxSelect,
  input  logic                     Mode,
  input  logic [NUM_CH-1:0]        ChMask,
  input  logic                     Start,
  input  logic                     OutReady,
  output logic [DATA_W-1:0]        Out,
  output logic [CH_W-1:0]          OutCh,
  output logic                     OutValid,
  output logic                     Busy,
  output logic                     Done
`ifdef SCAN_MUX_PARITY_EN
  ,
  output logic                     OutParity
`endif
);

  state_e state_q, state_d;

  logic [NUM_CH-1:0][DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]             mask_q;
  logic [CH_W-1:0]               ptr_q, ptr_d;
  logic [CH_W-1:0]               sel_ch, load_ch;
  logic [CH_W-1:0]               first_ch, adv_ch;
  logic                          first_found, adv_found;
  logic                          slot_free, load, clr_vld, done_d, mask_ld;

  assign ch_data   = MuxIn;
  assign slot_free = !OutValid || OutReady;
  assign sel_ch    = (32'(MuxSelect) < NUM_CH) ? MuxSelect : '0;
  assign Busy      = (state_q != IDLE);

  // First lookup searches the incoming mask from channel 0 inclusive.
  scan_mux_next_ch #(.NUM_CH(NUM_CH)) u_first (
    .mask  (ChMask),
    .ptr   ('0),
    .incl  (1'b1),
    .nxt   (first_ch),
    .found (first_found)
  );

  scan_mux_next_ch #(.NUM_CH(NUM_CH)) u_adv (
    .mask  (mask_q),
    .ptr   (ptr_q),
    .incl  (1'b0),
    .nxt   (adv_ch),
    .found (adv_found)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    load    = 1'b0;
    load_ch = '0;
    clr_vld = 1'b0;
    done_d  = 1'b0;
    mask_ld = 1'b0;
    case (state_q)
      IDLE: begin
        if (!Mode) begin
          load    = slot_free;
          load_ch = sel_ch;
        end else begin
          clr_vld = OutValid && OutReady;
          if (Start) begin
            mask_ld = 1'b1;
            if (first_found) begin
              ptr_d   = first_ch;
              state_d = SCAN;
            end else begin
              done_d  = 1'b1;
            end
          end
        end
      end
      SCAN: begin
        if (slot_free) begin
          load    = 1'b1;
          load_ch = ptr_q;
          if (adv_found) ptr_d   = adv_ch;
          else           state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (OutValid && OutReady) begin
          clr_vld = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      mask_q    <= '0;
      ptr_q     <= '0;
      Done      <= 1'b0;
      Out       <= '0;
      OutCh     <= '0;
      OutValid  <= 1'b0;
`ifdef SCAN_MUX_PARITY_EN
      OutParity <= 1'b0;
`endif
    end else begin
      ptr_q <= ptr_d;
      Done  <= done_d;
      if (mask_ld) mask_q <= ChMask;
      // A load may coincide with acceptance of the held beat.
      if (load) begin
        Out       <= ch_data[load_ch];
        OutCh     <= load_ch;
        OutValid  <= 1'b1;
`ifdef SCAN_MUX_PARITY_EN
        OutParity <= ^ch_data[load_ch];
`endif
      end else if (clr_vld) begin
        OutValid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: directed reset/direct/backpressure cases
// plus randomized direct and scan traffic against a queue-based reference.
module tb_scan_mux;

  localparam int NCH = 8;
  localparam int DW  = 4;
  localparam int CW  = 3;

  logic              Clock = 1'b0;
  logic              Resetn = 1'b0;
  logic [NCH*DW-1:0] MuxIn = '0;
  logic [CW-1:0]     MuxSelect = '0;
  logic              Mode = 1'b0;
  logic [NCH-1:0]    ChMask = '0;
  logic              Start = 1'b0;
  logic              OutReady = 1'b0;
  logic [DW-1:0]     Out;
  logic [CW-1:0]     OutCh;
  logic              OutValid, Busy, Done;
`ifdef SCAN_MUX_PARITY_EN
  logic              OutParity;
`endif

  int checks = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  scan_mux #(.NUM_CH(NCH), .DATA_W(DW)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .MuxIn     (MuxIn),
    .MuxSelect (MuxSelect),
    .Mode      (Mode),
    .ChMask    (ChMask),
    .Start     (Start),
    .OutReady  (OutReady),
    .Out       (Out),
    .OutCh     (OutCh),
    .OutValid  (OutValid),
    .Busy      (Busy),
    .Done      (Done)
`ifdef SCAN_MUX_PARITY_EN
    ,
    .OutParity (OutParity)
`endif
  );

  function automatic logic [DW-1:0] chd(input logic [NCH*DW-1:0] m, input int c);
    return m[c*DW +: DW];
  endfunction

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if (Out !== '0 || OutCh !== '0 || OutValid !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
      failures++;
      $display("FAIL %s: out=%h ch=%0d vld=%b busy=%b done=%b, want all 0",
               nm, Out, OutCh, OutValid, Busy, Done);
    end
`ifdef SCAN_MUX_PARITY_EN
    checks++;
    if (OutParity !== 1'b0) begin
      failures++;
      $display("FAIL %s_parity: got %b want 0", nm, OutParity);
    end
`endif
  endtask

  task automatic test_reset();
    logic [NCH-1:0] pat;
    logic [CW-1:0]  sels [3];
    logic [DW-1:0]  want;
    pat = 8'b1010_0110;
    for (int c = 0; c < NCH; c++) MuxIn[c*DW +: DW] = {3'b000, pat[c]};
    Mode = 1'b0; OutReady = 1'b1; MuxSelect = 3'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_zero("reset_hold");
    end
    Resetn = 1'b1;
    sels[0] = 3'd2; sels[1] = 3'd7; sels[2] = 3'd0;
    for (int i = 0; i < 3; i++) begin
      MuxSelect = sels[i];
      tick();
      want = {3'b000, pat[sels[i]]};
      checks++;
      if (Out !== want || OutCh !== sels[i] || OutValid !== 1'b1) begin
        failures++;
        $display("FAIL direct_sel%0d: out=%h ch=%0d vld=%b want out=%h ch=%0d vld=1",
                 sels[i], Out, OutCh, OutValid, want, sels[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    MuxIn = 32'h8765_4321;
    MuxSelect = 3'd1; OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      MuxSelect = (i < 2) ? 3'd1 : 3'd3;
      tick();
      checks++;
      if (Out !== chd(MuxIn, 1) || OutCh !== 3'd1 || OutValid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold%0d: out=%h ch=%0d vld=%b want out=%h ch=1 vld=1",
                 i, Out, OutCh, OutValid, chd(MuxIn, 1));
      end
    end
    OutReady = 1'b1;
    tick();
    checks++;
    if (Out !== chd(MuxIn, 3) || OutCh !== 3'd3 || OutValid !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: out=%h ch=%0d vld=%b want out=%h ch=3 vld=1",
               Out, OutCh, OutValid, chd(MuxIn, 3));
    end
  endtask

  task automatic test_direct_random();
    logic [DW-1:0]     eo;
    logic [CW-1:0]     ec, s;
    logic              ev, r;
    logic [NCH*DW-1:0] m;
    m = $urandom; MuxIn = m; MuxSelect = 3'd0; OutReady = 1'b1;
    ev = 1'b1; eo = chd(m, 0); ec = 3'd0;
    tick();
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (Out !== eo || OutCh !== ec || OutValid !== ev) begin
        failures++;
        $display("FAIL direct_rand%0d: out=%h ch=%0d vld=%b want out=%h ch=%0d vld=%b",
                 i, Out, OutCh, OutValid, eo, ec, ev);
      end
`ifdef SCAN_MUX_PARITY_EN
      checks++;
      if (OutParity !== ^eo) begin
        failures++;
        $display("FAIL direct_rand_parity%0d: got %b want %b", i, OutParity, ^eo);
      end
`endif
      m = $urandom; s = CW'($urandom); r = 1'($urandom);
      MuxIn = m; MuxSelect = s; OutReady = r;
      if (!ev || r) begin
        ev = 1'b1; eo = chd(m, int'(s)); ec = s;
      end
      tick();
    end
  endtask

`ifdef SCAN_MUX_PARITY_EN
  task automatic test_parity();
    MuxIn = '0;
    MuxIn[5*DW +: DW] = 4'b1011;
    MuxIn[6*DW +: DW] = 4'b0110;
    Mode = 1'b0; OutReady = 1'b1; MuxSelect = 3'd5;
    tick();
    checks++;
    if (Out !== 4'b1011 || OutParity !== 1'b1) begin
      failures++;
      $display("FAIL parity_odd: out=%h par=%b want out=b par=1", Out, OutParity);
    end
    MuxSelect = 3'd6;
    tick();
    checks++;
    if (Out !== 4'b0110 || OutParity !== 1'b0) begin
      failures++;
      $display("FAIL parity_even: out=%h par=%b want out=6 par=0", Out, OutParity);
    end
  endtask
`endif

  task automatic drain();
    Mode = 1'b1; OutReady = 1'b1;
    tick(); tick();
    checks++;
    if (OutValid !== 1'b0 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL drain: vld=%b busy=%b want 0 0", OutValid, Busy);
    end
  endtask

  // Reference: expected beats are the set mask bits in ascending order, each
  // carrying that channel's data; Done follows the last acceptance by one cycle.
  // rk: 0 = ready always high, 1 = toggling, 2 = random.
  task automatic run_scan(input logic [NCH-1:0] mask, input int rk,
                          input int stop_after, output int done_at);
    int            exp_q[$];
    int            got, cyc, e;
    bit            want_done, fin, p_stall;
    logic          r;
    logic [DW-1:0] p_out;
    logic [CW-1:0] p_ch;
    got = 0; cyc = 0; fin = 0; p_stall = 0; p_out = '0; p_ch = '0;
    done_at = -1;
    for (int c = 0; c < NCH; c++) if (mask[c]) exp_q.push_back(c);
    want_done = (exp_q.size() == 0);
    ChMask = mask; Mode = 1'b1; Start = 1'b1; OutReady = 1'b0;
    tick();
    Start = 1'b0; ChMask = NCH'($urandom); MuxSelect = CW'($urandom);
    if (mask != '0) Mode = 1'($urandom);
    while (!fin && cyc < 200) begin
      cyc++;
      checks++;
      if (Done !== want_done) begin
        failures++;
        $display("FAIL scan_done cyc%0d: done=%b want %b", cyc, Done, want_done);
      end
      checks++;
      if (Busy !== ((mask != '0) && !want_done)) begin
        failures++;
        $display("FAIL scan_busy cyc%0d: busy=%b want %b", cyc, Busy, (mask != '0) && !want_done);
      end
      if (p_stall) begin
        checks++;
        if (Out !== p_out || OutCh !== p_ch || OutValid !== 1'b1) begin
          failures++;
          $display("FAIL scan_hold cyc%0d: out=%h ch=%0d vld=%b want out=%h ch=%0d vld=1",
                   cyc, Out, OutCh, OutValid, p_out, p_ch);
        end
      end
      if (want_done) begin
        checks++;
        if (OutValid !== 1'b0) begin
          failures++;
          $display("FAIL scan_end_vld: vld=%b want 0", OutValid);
        end
        done_at = cyc; fin = 1; Mode = 1'b1;
      end else begin
        case (rk)
          0:       r = 1'b1;
          1:       r = cyc[0];
          default: r = 1'($urandom);
        endcase
        OutReady = r;
        if (OutValid && r) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scan_extra_beat: ch=%0d want none", OutCh);
          end else begin
            e = exp_q.pop_front();
            if (OutCh !== CW'(e) || Out !== chd(MuxIn, e)) begin
              failures++;
              $display("FAIL scan_beat%0d: ch=%0d out=%h want ch=%0d out=%h",
                       got, OutCh, Out, e, chd(MuxIn, e));
            end
          end
          got++;
          if (exp_q.size() == 0) want_done = 1;
        end
        p_stall = OutValid && !r; p_out = Out; p_ch = OutCh;
        if (stop_after >= 0 && got == stop_after) return;
        tick();
      end
    end
    if (!fin) begin
      checks++; failures++;
      $display("FAIL scan_timeout: no Done within 200 cycles, mask=%b", mask);
    end
  endtask

  task automatic test_empty_mask();
    int da;
    run_scan('0, 0, -1, da);
    checks++;
    if (da !== 1) begin
      failures++;
      $display("FAIL empty_done_at: got %0d want 1", da);
    end
  endtask

  task automatic test_full_scan();
    int da;
    for (int c = 0; c < NCH; c++) MuxIn[c*DW +: DW] = DW'(c + 1);
    run_scan(8'b1001_0010, 0, -1, da);
    checks++;
    if (da !== 5) begin
      failures++;
      $display("FAIL full_scan_done_at: got %0d want 5", da);
    end
  endtask

  task automatic test_random_scans();
    int da;
    for (int i = 0; i < 10; i++) begin
      MuxIn = $urandom;
      run_scan(NCH'($urandom), 2, -1, da);
    end
    // back-to-back full-throughput scans
    for (int i = 0; i < 3; i++) begin
      MuxIn = $urandom;
      run_scan(NCH'($urandom) | 8'h01, 0, -1, da);
    end
  endtask

  task automatic test_reset_mid_scan();
    int da;
    MuxIn = $urandom;
    run_scan(8'hFF, 1, 4, da);
    Resetn = 1'b0;
    #1;
    check_zero("midscan_reset");
    Mode = 1'b1; Start = 1'b0; OutReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_zero("midscan_reset_hold");
    end
    Resetn = 1'b1;
    tick();
    check_zero("post_reset_idle");
    run_scan(8'hFF, 2, -1, da);
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_direct_random();
`ifdef SCAN_MUX_PARITY_EN
    test_parity();
`endif
    drain();
    test_empty_mask();
    test_full_scan();
    test_random_scans();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_mux.md
Name: scan_mux

Overview:
- Parametrised, registered N-channel, W-bit multiplexer with valid/ready output.
- Two modes:
  - Direct: a registered select-driven mux.
  - Scan: a sequencer that walks enabled channels in ascending order, one beat per accepted transfer.
- Sits between a bank of sampled inputs (switches, sensor bits) and a single serial consumer (display driver, shift-out logic).

Parameters:
- NUM_CH, 8: number of input channels; 2..64.
- DATA_W, 1: bits per channel.
- CH_W, $clog2(NUM_CH): channel-index width; derived, not overridden.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- MuxIn  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
- MuxSelect  in  CH_W  channel index used in direct mode.
- Mode  in  1  0 = direct, 1 = scan; sampled only in IDLE.
- ChMask  in  NUM_CH  scan enable per channel; sampled on Start.
- Start  in  1  single-cycle pulse; begins a scan when Mode=1 in IDLE.
- OutReady  in  1  consumer accepts beat when OutValid && OutReady.
- Out  out  DATA_W  registered selected data.
- OutCh  out  CH_W  channel index that produced Out.
- OutValid  out  1  Out/OutCh hold a beat.
- Busy  out  1  high in SCAN or FLUSH.
- Done  out  1  one-cycle pulse when a scan completes.

Behaviour:
- Reset: asynchronous, active-low; one clock, no other reset.
  - Resetn low forces: state = IDLE, Out = 0, OutCh = 0, OutValid = 0, Busy = 0, Done = 0, mask register = 0, pointer = 0.
  - Reset mid-scan abandons the scan; no Done is issued.
- Output register load: "slot free" = !OutValid || OutReady.
  - When the slot is not free, Out, OutCh and OutValid hold stable.
- IDLE, Mode=0 (direct):
  - Each cycle the slot is free: Out <= MuxIn[MuxSelect], OutCh <= MuxSelect, OutValid <= 1.
  - Latency: 1 cycle from MuxSelect/MuxIn to Out.
  - MuxSelect >= NUM_CH selects channel 0; OutCh reports 0.
- IDLE, Mode=1:
  - OutValid clears once the held beat is accepted; nothing new is loaded.
  - On Start:
    - mask <= ChMask.
    - If mask is nonzero: pointer <= lowest set bit; go to SCAN.
    - If mask is zero: Done pulses the next cycle; stay in IDLE.
- SCAN:
  - When the slot is free: load MuxIn[pointer] into Out with OutCh = pointer and OutValid = 1.
  - Then advance the pointer to the next higher set mask bit.
  - If none remains, go to FLUSH.
  - MuxIn is sampled at load time, not at Start.
- FLUSH:
  - Wait until the last beat is accepted (OutValid && OutReady).
  - Then pulse Done in the next cycle, clear OutValid and return to IDLE.
- Busy = (state != IDLE).
- Start, Mode and MuxSelect changes while Busy are ignored.
- Start in IDLE with Mode=0 is ignored.
- Simultaneous acceptance and load in the same cycle is allowed: full throughput of 1 beat/cycle when OutReady is held high.
- Scan length equals popcount(ChMask); no wrap-around. The pointer never revisits a channel within one scan.

Optional Feature:
- Macro: SCAN_MUX_PARITY_EN.
- Defined:
  - Adds output OutParity (1 bit) = even parity (XOR) of Out.
  - OutParity is registered alongside Out and has the same hold/reset behaviour; reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package scan_mux_pkg holds:
  - state enum (IDLE, SCAN, FLUSH), 2 bits.
  - MAX_CH = 64.
  - a function returning the next set-bit index above a given position (priority search).
- Sub-module: scan_mux_next_ch, a combinational priority encoder.
  - Inputs: mask, current pointer. Outputs: next index, found flag.
  - Used for both the first-channel and the advance lookup.

Test Plan:
- Reset/direct: NUM_CH=8, DATA_W=1, MuxIn=8'b1010_0110, Resetn low then high.
  - Outputs are 0 during reset.
  - MuxSelect=2 -> Out=1, OutCh=2, OutValid=1 one cycle later.
  - MuxSelect=7 -> Out=1; MuxSelect=0 -> Out=0.
- Backpressure: direct mode with OutReady=0 for 5 cycles while MuxSelect changes 1->3.
  - Out/OutCh stay at the channel-1 beat.
  - OutReady=1 -> the channel-3 beat appears next cycle.
- Full scan: DATA_W=4, MuxIn channel c = c+1, ChMask=8'b1001_0010, Start, OutReady=1.
  - Beats (OutCh, Out) = (1,2), (4,5), (7,8) on consecutive cycles.
  - Done pulses once; Busy falls with Done.
- Empty mask: ChMask=0, Start in Mode=1 -> no OutValid, Done pulses the cycle after Start, Busy stays 0.
- Stall plus reset mid-scan: ChMask=8'hFF, OutReady toggling 1/0.
  - Beats must arrive in order 0..3 with none skipped.
  - Assert Resetn low after beat 3 -> all outputs 0 immediately, no Done.
  - A subsequent Start rescans from channel 0.
- Parity (SCAN_MUX_PARITY_EN): DATA_W=4, Out=4'b1011 -> OutParity=1; Out=4'b0110 -> OutParity=0.
